frame_tx: RTL

Transmit-side frame formatter that drains packets from the packet FIFO (words tagged with start-of-packet and end-of-packet flags) and emits framed packets on a valid/ready stream. Each frame is a header word (tag and sequence number), the payload words, and an optional length/checksum trailer. It sits directly on the FIFO read port: it drives `rd_en` and consumes `rd_data`, `ff_in_sop`, `ff_in_eop` and `read_empty`.

---
 rtl/frame_tx.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/frame_tx.sv
// rtl/frame_tx.sv - packet FIFO to framed valid/ready stream formatter; trailer feature under FRAME_TX_TRAILER_EN
module frame_tx #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [7:0] HDR_TAG    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  sw_rst,
    input  logic                  enable,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  ff_in_sop,
    input  logic                  ff_in_eop,
    input  logic                  read_empty,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_sof,
    output logic                  tx_eof,
    output logic                  frame_done,
    output logic                  proto_err,
    output logic                  busy
);

`ifdef FRAME_TX_TRAILER_EN
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2, TRL = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2} state_t;
`endif

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   buf_data [2];
    logic                    buf_sop  [2];
    logic                    buf_eop  [2];
    logic [1:0]              cnt_q;
    logic                    infl_q;
    logic                    rst_hold_q;
    logic [7:0]              seq_q;
    logic                    frame_done_q;
    logic                    proto_err_q;
    logic                    pop;
    logic                    cap_keep;
    logic                    idle_drop;
    logic                    last_xfer;
    logic                    eop_pending;
    logic                    rd_state_ok;
    logic [2:0]              fill;
`ifdef FRAME_TX_TRAILER_EN
    logic [15:0]             len_q;
    logic [15:0]             csum_q;
`endif

    // Read gating: only issue a read when the word is guaranteed a buffer slot and the current packet's EOP is not yet fetched
    always_comb begin
        pop         = (state_q == PAY) && tx_valid && tx_ready;
        eop_pending = ((cnt_q != 2'd0) && buf_eop[0]) || ((cnt_q == 2'd2) && buf_eop[1]) || (infl_q && ff_in_eop);
        fill        = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
        rd_state_ok = (state_q == IDLE) ? (enable && (cnt_q == 2'd0)) : ((state_q == HDR) || (state_q == PAY));
        rd_en       = !sw_rst && !rst_hold_q && !read_empty && (fill < 3'd2) && !eop_pending && rd_state_ok;
        cap_keep    = infl_q && ((state_q != IDLE) || ff_in_sop);
        idle_drop   = infl_q && (state_q == IDLE) && !ff_in_sop;
    end

    // Next-state and stream outputs; the buffer head is held until it transfers so stalls keep data stable
    always_comb begin
        state_d   = state_q;
        tx_valid  = 1'b0;
        tx_data   = '0;
        tx_sof    = 1'b0;
        tx_eof    = 1'b0;
        last_xfer = 1'b0;
        case (state_q)
            IDLE: begin
                if (infl_q && ff_in_sop) state_d = HDR;
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_sof   = 1'b1;
                tx_data  = {HDR_TAG, 16'h0000, seq_q};
                if (tx_ready) state_d = PAY;
            end
            PAY: begin
                tx_valid = (cnt_q != 2'd0);
                tx_data  = buf_data[0];
`ifdef FRAME_TX_TRAILER_EN
                if (pop && buf_eop[0]) state_d = TRL;
`else
                tx_eof = (cnt_q != 2'd0) && buf_eop[0];
                if (pop && buf_eop[0]) begin
                    state_d   = IDLE;
                    last_xfer = 1'b1;
                end
`endif
            end
`ifdef FRAME_TX_TRAILER_EN
            TRL: begin
                tx_valid = 1'b1;
                tx_eof   = 1'b1;
                tx_data  = {len_q, csum_q};
                if (tx_ready) begin
                    state_d   = IDLE;
                    last_xfer = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Control state, sequence number and registered pulses
    always_ff @(posedge clk) begin
        if (sw_rst) begin
            state_q      <= IDLE;
            infl_q       <= 1'b0;
            rst_hold_q   <= 1'b1;
            seq_q        <= 8'h00;
            frame_done_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            infl_q       <= rd_en;
            rst_hold_q   <= 1'b0;
            frame_done_q <= last_xfer;
            proto_err_q  <= idle_drop || (pop && buf_sop[0]);
            if (last_xfer) seq_q <= seq_q + 8'd1;
        end
    end

    // Two-entry payload buffer; entry 0 is the head. The SOP of the packet's first word is not kept, so a stored SOP flags a missing EOP
    always_ff @(posedge clk) begin
        if (sw_rst) begin
            cnt_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_sop[i]  <= 1'b0;
                buf_eop[i]  <= 1'b0;
            end
        end else begin
            case ({pop, cap_keep})
                2'b10: begin
                    buf_data[0] <= buf_data[1];
                    buf_sop[0]  <= buf_sop[1];
                    buf_eop[0]  <= buf_eop[1];
                    cnt_q       <= cnt_q - 2'd1;
                end
                2'b01: begin
                    if (cnt_q == 2'd0) begin
                        buf_data[0] <= rd_data;
                        buf_sop[0]  <= ff_in_sop && (state_q != IDLE);
                        buf_eop[0]  <= ff_in_eop;
                    end else begin
                        buf_data[1] <= rd_data;
                        buf_sop[1]  <= ff_in_sop;
                        buf_eop[1]  <= ff_in_eop;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        buf_data[0] <= rd_data;
                        buf_sop[0]  <= ff_in_sop;
                        buf_eop[0]  <= ff_in_eop;
                    end else begin
                        buf_data[0] <= buf_data[1];
                        buf_sop[0]  <= buf_sop[1];
                        buf_eop[0]  <= buf_eop[1];
                        buf_data[1] <= rd_data;
                        buf_sop[1]  <= ff_in_sop;
                        buf_eop[1]  <= ff_in_eop;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FRAME_TX_TRAILER_EN
    // Saturating length and folded XOR checksum of transferred payload words, cleared at frame end
    always_ff @(posedge clk) begin
        if (sw_rst || last_xfer) begin
            len_q  <= 16'h0000;
            csum_q <= 16'h0000;
        end else if (pop) begin
            if (len_q != 16'hFFFF) len_q <= len_q + 16'd1;
            csum_q <= csum_q ^ buf_data[0][31:16] ^ buf_data[0][15:0];
        end
    end
`endif

    assign frame_done = frame_done_q;
    assign proto_err  = proto_err_q;
    assign busy       = (state_q != IDLE);

endmodule
